// File: rtl/wm_control_panel_if.sv
// Front-panel bundle between the raw panel/sensors, the conditioning stage
// and the downstream sequencing FSM.
// Contract: `start` is a single-cycle event the FSM must consume on the cycle
// it is high. `program_selection` is stable for the whole run it belongs to.
// `program_done` is a level that may stay high for any number of cycles.
interface wm_control_panel_if;
    // raw panel and sensor inputs, plus the level coming back from the FSM
    logic       power_sw;
    logic       start_btn;
    logic       door_sensor;
    logic       soap_sensor;
    logic [2:0] prog_sw;
    logic       program_done;
    // conditioned outputs
    logic       power;
    logic       start;
    logic       doorclosed;
    logic       soap;
    logic [2:0] program_selection;
    logic       door_lock;
    logic       busy;
    logic       invalid_prog;
    // current interlock state, for observation only
    logic [2:0] state_dbg;

    modport master (
        output power_sw, start_btn, door_sensor, soap_sensor, prog_sw, program_done,
        input  power, start, doorclosed, soap, program_selection,
        input  door_lock, busy, invalid_prog, state_dbg
    );

    modport slave (
        input  power_sw, start_btn, door_sensor, soap_sensor, prog_sw, program_done,
        output power, start, doorclosed, soap, program_selection,
        output door_lock, busy, invalid_prog, state_dbg
    );
endinterface

// File: rtl/wm_control_panel.sv
// Washing-machine front-panel conditioning: synchronise and debounce the raw
// inputs, validate and freeze the program selection, and run the door-lock
// interlock that feeds the sequencing FSM.
module wm_control_panel #(
    parameter int DB_CYCLES   = 8,
    parameter int DB_W        = 4,
    parameter int LOCK_CYCLES = 4,
    parameter int LOCK_W      = 3
) (
    input logic               clk,
    input logic               rst,
    wm_control_panel_if.slave bus
);
    localparam logic [2:0] ST_OFF     = 3'd0;
    localparam logic [2:0] ST_READY   = 3'd1;
    localparam logic [2:0] ST_LOCKING = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_UNLOCK  = 3'd4;

    // Counters compare against N-1 so the flip lands on the Nth differing cycle.
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

    // Single-bit channels: 0 power, 1 start, 2 door, 3 soap; bits 6:4 carry prog_sw.
    logic [6:0] raw;
    assign raw = {bus.prog_sw, bus.soap_sensor, bus.door_sensor, bus.start_btn, bus.power_sw};

    logic [6:0]      sync1_q, sync2_q;
    logic [3:0]      bit_db_q, bit_db_d;
    logic [DB_W-1:0] bit_cnt_q [4];
    logic [DB_W-1:0] bit_cnt_d [4];
    logic [2:0]      prog_db_q, prog_db_d;
    logic [DB_W-1:0] prog_cnt_q, prog_cnt_d;

    logic [2:0]        state_q, state_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              start_prev_q, start_prev_d;
    logic              in_run_q, in_run_d;

    logic       power_q, power_d;
    logic       start_q, start_d;
    logic       door_q, door_d;
    logic       soap_q, soap_d;
    logic [2:0] prog_sel_q, prog_sel_d;
    logic       door_lock_q, door_lock_d;
    logic       busy_q, busy_d;
    logic       invalid_q, invalid_d;

    logic power_db, door_db, start_evt, engaged;
    assign power_db  = bit_db_q[0];
    assign door_db   = bit_db_q[2];
    assign start_evt = bit_db_q[1] & ~start_prev_q;
    assign engaged   = (state_q == ST_LOCKING) || (state_q == ST_RUN) || (state_q == ST_UNLOCK);

    // Debounce: the count restarts whenever synced and debounced agree.
    always_comb begin
        bit_db_d = bit_db_q;
        for (int i = 0; i < 4; i++) begin
            bit_cnt_d[i] = '0;
            if (sync2_q[i] != bit_db_q[i]) begin
                if (bit_cnt_q[i] == DB_LAST) bit_db_d[i] = sync2_q[i];
                else                         bit_cnt_d[i] = bit_cnt_q[i] + DB_W'(1);
            end
        end
        prog_db_d  = prog_db_q;
        prog_cnt_d = '0;
        if (sync2_q[6:4] != prog_db_q) begin
            if (prog_cnt_q == DB_LAST) prog_db_d  = sync2_q[6:4];
            else                       prog_cnt_d = prog_cnt_q + DB_W'(1);
        end
    end

    // Interlock state machine; power loss wins everywhere except UNLOCK.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = '0;
        case (state_q)
            ST_OFF:   if (power_db) state_d = ST_READY;
            ST_READY: begin
                if (!power_db)                                        state_d = ST_OFF;
                else if (start_evt && door_db && prog_db_q <= 3'd3)   state_d = ST_LOCKING;
            end
            ST_LOCKING: begin
                if (!power_db)                    state_d = ST_OFF;
                else if (!door_db)                state_d = ST_READY;
                else if (lock_cnt_q == LOCK_LAST) state_d = ST_RUN;
                else                              lock_cnt_d = lock_cnt_q + LOCK_W'(1);
            end
            ST_RUN: if (!power_db || bus.program_done) state_d = ST_UNLOCK;
            ST_UNLOCK: begin
                if (lock_cnt_q == LOCK_LAST) state_d = power_db ? ST_READY : ST_OFF;
                else                         lock_cnt_d = lock_cnt_q + LOCK_W'(1);
            end
            default: state_d = ST_OFF;
        endcase
    end

    // Output decode from the current state; outputs follow a transition by one cycle.
    always_comb begin
        start_prev_d = bit_db_q[1];
        in_run_d     = (state_q == ST_RUN);
        power_d      = power_db;
        door_d       = door_db;
        soap_d       = bit_db_q[3];
        start_d      = (state_q == ST_RUN) && !in_run_q;
        door_lock_d  = engaged;
        busy_d       = engaged;
        invalid_d    = (state_q == ST_READY) && (prog_db_q > 3'd3);
        prog_sel_d   = engaged ? prog_sel_q : prog_db_q;
    end

    // All state, including the solenoid drive, clears asynchronously on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            bit_db_q     <= '0;
            for (int i = 0; i < 4; i++) bit_cnt_q[i] <= '0;
            prog_db_q    <= '0;
            prog_cnt_q   <= '0;
            state_q      <= ST_OFF;
            lock_cnt_q   <= '0;
            start_prev_q <= 1'b0;
            in_run_q     <= 1'b0;
            power_q      <= 1'b0;
            start_q      <= 1'b0;
            door_q       <= 1'b0;
            soap_q       <= 1'b0;
            prog_sel_q   <= '0;
            door_lock_q  <= 1'b0;
            busy_q       <= 1'b0;
            invalid_q    <= 1'b0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            bit_db_q     <= bit_db_d;
            for (int i = 0; i < 4; i++) bit_cnt_q[i] <= bit_cnt_d[i];
            prog_db_q    <= prog_db_d;
            prog_cnt_q   <= prog_cnt_d;
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            start_prev_q <= start_prev_d;
            in_run_q     <= in_run_d;
            power_q      <= power_d;
            start_q      <= start_d;
            door_q       <= door_d;
            soap_q       <= soap_d;
            prog_sel_q   <= prog_sel_d;
            door_lock_q  <= door_lock_d;
            busy_q       <= busy_d;
            invalid_q    <= invalid_d;
        end
    end

    assign bus.power             = power_q;
    assign bus.start             = start_q;
    assign bus.doorclosed        = door_q;
    assign bus.soap              = soap_q;
    assign bus.program_selection = prog_sel_q;
    assign bus.door_lock         = door_lock_q;
    assign bus.busy              = busy_q;
    assign bus.invalid_prog      = invalid_q;
    assign bus.state_dbg         = state_q;
endmodule
